// File: rtl/addr_seq.sv
// Address sequencer: walks STEPS addresses, holding each for DWELL cycles, with start/stop/loop control.
// Optional remap table enabled by defining ADDR_SEQ_REMAP_EN.
module addr_seq #(
  parameter  int ADDR_W = 4,
  parameter  int STEPS  = 16,
  parameter  int DWELL  = 13,
  localparam int STEP_W = $clog2(STEPS),
  localparam int DW_W   = $clog2(DWELL + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
`ifdef ADDR_SEQ_REMAP_EN
  input  logic              map_we,
  input  logic [STEP_W-1:0] map_idx,
  input  logic [ADDR_W-1:0] map_data,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              out_trig,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_idx
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(STEPS - 1);
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);

  state_t              state, state_nxt;
  logic [DW_W-1:0]     dwell, dwell_nxt;
  logic [STEP_W-1:0]   step_nxt, step_inc;
  logic [ADDR_W-1:0]   addr_nxt, map_first, map_inc;
  logic                trig_nxt, busy_nxt, done_nxt;
  logic                go, dwell_end, last_step;

  assign go        = start && !stop;
  assign dwell_end = (dwell == DWELL_LAST);
  assign last_step = (step_idx == LAST_STEP);
  assign step_inc  = step_idx + STEP_W'(1);

`ifdef ADDR_SEQ_REMAP_EN
  logic [ADDR_W-1:0] map_tbl [STEPS];
  logic              map_wr;

  // Table is only writable while idle and not on the edge that starts a sweep.
  assign map_wr = map_we && (state == IDLE) && !start &&
                  ({1'b0, map_idx} < (STEP_W + 1)'(STEPS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) map_tbl[i] <= ADDR_W'(i);
    end else if (map_wr) begin
      map_tbl[map_idx] <= map_data;
    end
  end

  assign map_first = map_tbl[0];
  assign map_inc   = map_tbl[step_inc];
`else
  assign map_first = '0;
  assign map_inc   = ADDR_W'(step_inc);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go) state_nxt = RUN;
      RUN:  if (stop || (dwell_end && last_step && !loop)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stop overrides everything in RUN; leaving RUN always returns outputs to zero.
  always_comb begin
    dwell_nxt = '0;
    step_nxt  = '0;
    addr_nxt  = '0;
    trig_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          busy_nxt = 1'b1;
          addr_nxt = map_first;
          trig_nxt = 1'b1;
        end
      end
      RUN: begin
        if (!stop) begin
          busy_nxt  = 1'b1;
          step_nxt  = step_idx;
          addr_nxt  = addr;
          dwell_nxt = dwell + DW_W'(1);
          if (dwell_end) begin
            dwell_nxt = '0;
            if (!last_step) begin
              step_nxt = step_inc;
              addr_nxt = map_inc;
            end else if (loop) begin
              step_nxt = '0;
              addr_nxt = map_first;
              trig_nxt = 1'b1;
            end else begin
              busy_nxt = 1'b0;
              step_nxt = '0;
              addr_nxt = '0;
              done_nxt = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell    <= '0;
      step_idx <= '0;
      addr     <= '0;
      out_trig <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      dwell    <= dwell_nxt;
      step_idx <= step_nxt;
      addr     <= addr_nxt;
      out_trig <= trig_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_addr_seq.sv
// Self-checking bench for addr_seq: default-parameter instance driven from a vector table,
// plus a STEPS=4/DWELL=1 instance and async-reset / remap sequences.
module tb_addr_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [3:0] addr, step_idx;
  logic       out_trig, busy, done;

  logic       s_start = 1'b0, s_stop = 1'b0, s_loop = 1'b0;
  logic [3:0] s_addr;
  logic [1:0] s_step;
  logic       s_trig, s_busy, s_done;

`ifdef ADDR_SEQ_REMAP_EN
  logic       map_we = 1'b0;
  logic [3:0] map_idx = '0;
  logic [3:0] map_data = '0;
`endif

  always #5 clk = ~clk;

  addr_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
`ifdef ADDR_SEQ_REMAP_EN
    .map_we(map_we), .map_idx(map_idx), .map_data(map_data),
`endif
    .addr(addr), .out_trig(out_trig), .busy(busy), .done(done), .step_idx(step_idx)
  );

  addr_seq #(.ADDR_W(4), .STEPS(4), .DWELL(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .stop(s_stop), .loop(s_loop),
`ifdef ADDR_SEQ_REMAP_EN
    .map_we(1'b0), .map_idx(2'b00), .map_data(4'b0000),
`endif
    .addr(s_addr), .out_trig(s_trig), .busy(s_busy), .done(s_done), .step_idx(s_step)
  );

  typedef struct {
    int         cyc;
    logic       start, stop, loop;
    logic [3:0] addr, step;
    logic       trig, busy, done;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0, n_bad = 0;
  int   cyc = -1;
  int   trig_cnt = 0, done_cnt = 0;
  bit   count_en = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (count_en) begin
      trig_cnt += int'(out_trig);
      done_cnt += int'(done);
    end
  endtask

  task automatic apply_stimulus(input logic st, input logic sp, input logic lp);
    start = st;
    stop  = sp;
    loop  = lp;
  endtask

  task automatic add_vec(input int c, input logic st, input logic sp, input logic lp,
                         input logic [3:0] a, input logic [3:0] s,
                         input logic t, input logic b, input logic d);
    vec_t v;
    v.cyc = c; v.start = st; v.stop = sp; v.loop = lp;
    v.addr = a; v.step = s; v.trig = t; v.busy = b; v.done = d;
    vecs.push_back(v);
  endtask

  task automatic check_main(input string tag, input logic [3:0] a, input logic [3:0] s,
                            input logic t, input logic b, input logic d);
    check_output({tag, ".addr"}, 32'(addr), 32'(a));
    check_output({tag, ".step"}, 32'(step_idx), 32'(s));
    check_output({tag, ".trig"}, 32'(out_trig), 32'(t));
    check_output({tag, ".busy"}, 32'(busy), 32'(b));
    check_output({tag, ".done"}, 32'(done), 32'(d));
  endtask

  task automatic check_small(input string tag, input logic [3:0] a, input logic [1:0] s,
                             input logic t, input logic b, input logic d);
    check_output({tag, ".addr"}, 32'(s_addr), 32'(a));
    check_output({tag, ".step"}, 32'(s_step), 32'(s));
    check_output({tag, ".trig"}, 32'(s_trig), 32'(t));
    check_output({tag, ".busy"}, 32'(s_busy), 32'(b));
    check_output({tag, ".done"}, 32'(s_done), 32'(d));
  endtask

  initial begin
    // Each entry: inputs held on every edge up to and including that cycle, then outputs compared.
    //        cyc  st sp lp addr step trig busy done
    add_vec(  0, 1, 0, 0,  0,  0,  1, 1, 0);
    add_vec(  1, 0, 0, 0,  0,  0,  0, 1, 0);
    add_vec( 12, 0, 0, 0,  0,  0,  0, 1, 0);
    add_vec( 13, 0, 0, 0,  1,  1,  0, 1, 0);
    add_vec( 29, 0, 0, 0,  2,  2,  0, 1, 0);
    add_vec( 30, 1, 0, 0,  2,  2,  0, 1, 0);
    add_vec( 40, 1, 0, 0,  3,  3,  0, 1, 0);
    add_vec(181, 0, 0, 0, 13, 13,  0, 1, 0);
    add_vec(182, 0, 0, 0, 14, 14,  0, 1, 0);
    add_vec(194, 0, 0, 0, 14, 14,  0, 1, 0);
    add_vec(195, 0, 0, 0, 15, 15,  0, 1, 0);
    add_vec(207, 0, 0, 0, 15, 15,  0, 1, 0);
    add_vec(208, 1, 0, 0,  0,  0,  0, 0, 1);
    add_vec(209, 1, 0, 0,  0,  0,  1, 1, 0);
    add_vec(210, 0, 0, 0,  0,  0,  0, 1, 0);
    add_vec(258, 0, 0, 0,  3,  3,  0, 1, 0);
    add_vec(259, 0, 1, 0,  0,  0,  0, 0, 0);
    add_vec(261, 1, 1, 0,  0,  0,  0, 0, 0);
    add_vec(262, 1, 0, 0,  0,  0,  1, 1, 0);
    add_vec(263, 0, 0, 0,  0,  0,  0, 1, 0);
    add_vec(469, 0, 0, 1, 15, 15,  0, 1, 0);
    add_vec(470, 0, 0, 1,  0,  0,  1, 1, 0);
    add_vec(471, 0, 0, 1,  0,  0,  0, 1, 0);
    add_vec(483, 0, 0, 1,  1,  1,  0, 1, 0);
    add_vec(677, 0, 0, 0, 15, 15,  0, 1, 0);
    add_vec(678, 0, 0, 0,  0,  0,  0, 0, 1);
    add_vec(679, 0, 0, 0,  0,  0,  0, 0, 0);

    #2;
    check_main("reset", 0, 0, 0, 0, 0);
    check_small("reset_small", 0, 0, 0, 0, 0);
    #10 rst_n = 1'b1;

    count_en = 1'b1;
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].start, vecs[i].stop, vecs[i].loop);
      while (cyc < vecs[i].cyc) tick();
      check_main($sformatf("vec%0d", i), vecs[i].addr, vecs[i].step,
                 vecs[i].trig, vecs[i].busy, vecs[i].done);
    end
    count_en = 1'b0;
    apply_stimulus(0, 0, 0);
    check_output("trig_pulses", 32'(trig_cnt), 32'd4);
    check_output("done_pulses", 32'(done_cnt), 32'd2);

    // Asynchronous reset in the middle of a sweep, between clock edges.
    apply_stimulus(1, 0, 0);
    s_start = 1'b1;
    tick();
    apply_stimulus(0, 0, 0);
    s_start = 1'b0;
    repeat (100) tick();
    check_main("pre_rst", 7, 7, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check_main("async_rst", 0, 0, 0, 0, 0);
    check_small("async_rst_small", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // STEPS=4, DWELL=1: new address every cycle, done right after the last step.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check_small("small_c0", 0, 0, 1, 1, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_small($sformatf("small_c%0d", i), 4'(i), 2'(i), 0, 1, 0);
    end
    tick();
    check_small("small_c4", 0, 0, 0, 0, 1);
    tick();
    check_small("small_c5", 0, 0, 0, 0, 0);

    s_loop  = 1'b1;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    repeat (3) tick();
    check_small("small_loop_c3", 3, 3, 0, 1, 0);
    tick();
    check_small("small_loop_c4", 0, 0, 1, 1, 0);
    s_stop = 1'b1;
    tick();
    s_stop = 1'b0;
    s_loop = 1'b0;
    check_small("small_stop", 0, 0, 0, 0, 0);

`ifdef ADDR_SEQ_REMAP_EN
    map_we = 1'b1; map_idx = 4'd15; map_data = 4'd2;
    tick();
    map_we = 1'b0;
    apply_stimulus(1, 0, 0);
    tick();
    apply_stimulus(0, 0, 0);
    map_we = 1'b1; map_idx = 4'd15; map_data = 4'd7;
    tick();
    map_we = 1'b0;
    repeat (194) tick();
    check_main("remap_c195", 2, 15, 0, 1, 0);
    repeat (13) tick();
    check_main("remap_done", 0, 0, 0, 0, 1);
    apply_stimulus(1, 0, 0);
    tick();
    apply_stimulus(0, 0, 0);
    repeat (195) tick();
    check_main("remap_busy_wr", 2, 15, 0, 1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
